gain_apply: RTL and testbench
=============================

# gain_apply

Applies the coherent per-channel gain trim set to the ADC sample stream. It is the consumer end of the `gainToggle`/`gains` interface produced by the autotrim logic. A new gain set is captured when the toggle changes and switched into use only at the next frame boundary, so all channels change gain on the same sample. Scaled, rounded and saturated samples go to the downstream beam-position processing, and an applied-toggle is returned so firmware can confirm the update.

## Interface
- `NADC`, 4, number of ADC channels.
- `SAMPLE_WIDTH`, 16, signed two's-complement sample width, both in and out.
- `GAIN_WIDTH`, 25, unsigned gain width; unity = 2^(GAIN_WIDTH-1), range [0, 2).

- `clk` in 1: ADC sample clock, the single clock of the block.
- `resetN` in 1: asynchronous, active-low reset.
- `gainToggle` in 1: changes state once per new gain set.
- `gains` in NADC*GAIN_WIDTH: gain set, channel n at `[n*GAIN_WIDTH+:GAIN_WIDTH]`; stable whenever `gainToggle` changes.
- `gainEnable` in 1: 0 = bypass (unity gain applied regardless of stored gains).
- `satClearStrobe` in 1: clears the sticky saturation flags.
- `adcValid` in 1: sample qualifier.
- `adcFrame` in 1: qualified with `adcValid`; marks the first sample of a frame.
- `adcData` in NADC*SAMPLE_WIDTH: signed samples, same packing as `gains`.
- `outValid` out 1: output qualifier.
- `outFrame` out 1: `adcFrame` delayed to align with the output.
- `outData` out NADC*SAMPLE_WIDTH: scaled samples.
- `appliedToggle` out 1: mirrors `gainToggle` once that gain set is active.
- `pendingFlag` out 1: a captured gain set is waiting for a frame boundary.
- `satFlags` out NADC: sticky per-channel saturation indicators.

## Operation
- **Reset values:**
  - `pending` and `active` = unity for every channel.
  - `gainMatch`, `appliedToggle`, `pendingFlag`, `outValid`, `outFrame` = 0.
  - `outData` = 0; `satFlags` = 0.
  - Pipeline valid bits = 0.
- **Capture:**
  - `gainMatch` registers `gainToggle` every cycle.
  - When `gainToggle != gainMatch`: `pending <= gains`, `pendingTog <= gainToggle`, `pendingFlag <= 1`.
  - A later capture before a boundary overwrites `pending`; the last set wins and intermediate sets are never applied.
- **Commit:**
  - Condition: a cycle with `adcValid && adcFrame && pendingFlag`.
  - Action: `active <= pending`, `appliedToggle <= pendingTog`, `pendingFlag <= 0`.
  - The frame-start sample itself uses the new gains.
- **Capture and commit in the same cycle:**
  - The commit uses the old `pending` contents.
  - The new set goes into `pending`.
  - `pendingFlag` stays 1.
- **Datapath, per channel:**
  - `product = sample (signed) × {1'b0, gain}`, signed width SAMPLE_WIDTH+GAIN_WIDTH+1.
  - Round half up: add 2^(GAIN_WIDTH-2), then arithmetic shift right by GAIN_WIDTH-1.
  - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - When saturation is applied on a valid sample, set the corresponding `satFlags` bit.
- **Bypass:** when `gainEnable` = 0, the unity gain constant is used. The datapath and latency are unchanged, and `outData` equals `adcData` exactly.
- **Saturation flags:**
  - `satClearStrobe` clears all flags.
  - If a saturation event occurs in the same cycle as the clear, the set wins.
- Invalid samples (`adcValid` = 0) never commit gains, never set flags, and propagate `outValid` = 0.

## Timing
- Pipeline of 3 registered stages:
  - S1: register sample, frame bit, and the selected gain.
  - S2: multiply.
  - S3: round and saturate into the output registers.
- `outValid`, `outFrame` and `outData` appear 3 cycles after the matching `adcValid`.
- Full throughput: one sample per clock; no backpressure.
- Gain selection happens at S1 from `active` (or from `pending` on a commit cycle). The whole frame is therefore processed with one coherent gain set, even though changes reach the output 3 cycles later.
- `gainToggle` change to `pendingFlag` = 1: 1 cycle.
- Commit cycle to `appliedToggle` update: 1 cycle.
- `outData` holds its last value while `outValid` = 0.
- Reset asserted mid-stream:
  - All state returns to reset values immediately, including the pending gain set, which is discarded.
  - The first valid output after deassertion appears 3 cycles after the first `adcValid`.

## Test plan
- **Unity pass-through:** default gains, `adcData` ch0 = 1234, ch3 = -32768 → `outData` identical, 3 cycles later, `satFlags` = 0.
- **Rounding:** gains = 0x0800000 (0.5) on all channels, samples 3, -3, 1, -1 → outputs 2, -1, 1, 0.
- **Saturation:** gains = 0x1FFFFFF, samples 32767 and -32768 → outputs 32767 and -32768, `satFlags` bits set.
  - Then pulse `satClearStrobe` with no further saturation → `satFlags` = 0.
- **Coherent commit:** toggle `gainToggle` with gains = 0.5 in the middle of a frame → `pendingFlag` = 1 after 1 cycle; the remaining samples in that frame stay at unity.
  - The first sample flagged `adcFrame` and all later ones are halved.
  - `appliedToggle` equals `gainToggle` 1 cycle after the commit.
- **Last wins:** two toggles in one frame (0.5, then 0.25) → only 0.25 is applied at the boundary; 0.5 never appears on `outData`.
- **Reset:** assert `resetN` low with a pending set and a full pipeline → outputs clear immediately.
  - After release, samples pass at unity and `pendingFlag` = 0.

Source files
------------

// File: rtl/gain_apply.sv
// gain_apply
//   Applies a coherent per-channel gain trim set to the ADC sample stream.
//   A gain set is captured when gainToggle changes. It is switched into use
//   on the next frame-start sample, so every channel changes gain on the same
//   sample. Samples are scaled, rounded half up and saturated.
//
// Ports
//   clk            ADC sample clock
//   resetN         asynchronous active-low reset
//   gainToggle     changes once per new gain set
//   gains          gain set, channel n at [n*GAIN_WIDTH +: GAIN_WIDTH]
//   gainEnable     0 = bypass (unity gain)
//   satClearStrobe clears the sticky saturation flags
//   adcValid       input sample qualifier
//   adcFrame       first sample of a frame (qualified by adcValid)
//   adcData        signed samples, channel n at [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   outValid       output qualifier (3 cycles after adcValid)
//   outFrame       frame marker aligned with outData
//   outData        scaled samples; holds while outValid = 0
//   appliedToggle  toggle value of the gain set currently active
//   pendingFlag    a captured gain set is waiting for a frame boundary
//   satFlags       sticky per-channel saturation indicators
module gain_apply #(
  parameter int NADC         = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 25
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         gainToggle,
  input  logic [NADC*GAIN_WIDTH-1:0]   gains,
  input  logic                         gainEnable,
  input  logic                         satClearStrobe,
  input  logic                         adcValid,
  input  logic                         adcFrame,
  input  logic [NADC*SAMPLE_WIDTH-1:0] adcData,
  output logic                         outValid,
  output logic                         outFrame,
  output logic [NADC*SAMPLE_WIDTH-1:0] outData,
  output logic                         appliedToggle,
  output logic                         pendingFlag,
  output logic [NADC-1:0]              satFlags
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int GW = GAIN_WIDTH;
  localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  localparam logic [GW-1:0]          UNITY     = {1'b1, {(GW-1){1'b0}}};
  localparam logic [NADC*GW-1:0]     UNITY_ALL = {NADC{UNITY}};
  localparam logic signed [PW-1:0]   RND_C     = PW'(2**(GW-2));
  localparam logic signed [PW-1:0]   SAT_MAX   = PW'((2**(SW-1)) - 1);
  // ~MAX == -MAX-1 in two's complement
  localparam logic signed [PW-1:0]   SAT_MIN   = ~SAT_MAX;
  localparam logic [SW-1:0]          OUT_MAX   = {1'b0, {(SW-1){1'b1}}};
  localparam logic [SW-1:0]          OUT_MIN   = {1'b1, {(SW-1){1'b0}}};

  // gain set handshake state
  logic                 r_gain_match;
  logic                 r_pending_tog;
  logic                 r_pending_flag;
  logic                 r_applied_tog;
  logic [NADC*GW-1:0]   r_pending;
  logic [NADC*GW-1:0]   r_active;

  logic                 w_capture;
  logic                 w_commit;
  logic [NADC*GW-1:0]   w_gain_sel;

  // pipeline
  logic                 r_s1_valid;
  logic                 r_s1_frame;
  logic [NADC*SW-1:0]   r_s1_data;
  logic [NADC*GW-1:0]   r_s1_gain;

  logic                 r_s2_valid;
  logic                 r_s2_frame;
  logic signed [PW-1:0] r_s2_prod [NADC];

  logic                 r_out_valid;
  logic                 r_out_frame;
  logic [NADC*SW-1:0]   r_out_data;
  logic [NADC-1:0]      r_sat_flags;

  logic signed [PW-1:0] w_op_a [NADC];
  logic signed [PW-1:0] w_op_b [NADC];
  logic signed [PW-1:0] w_prod [NADC];
  logic signed [PW-1:0] w_rnd  [NADC];
  logic signed [PW-1:0] w_shr  [NADC];
  logic [NADC*SW-1:0]   w_res;
  logic [NADC-1:0]      w_sat;

  assign w_capture = (gainToggle != r_gain_match);
  assign w_commit  = adcValid & adcFrame & r_pending_flag;

  // On a commit cycle the frame-start sample must already see the new set,
  // so it is taken straight from pending rather than waiting for active.
  always_comb begin
    w_gain_sel = r_active;
    if (!gainEnable) begin
      w_gain_sel = UNITY_ALL;
    end else if (w_commit) begin
      w_gain_sel = r_pending;
    end
  end

  // Capture and commit may coincide: commit takes the old pending contents
  // while the new set lands in pending and keeps the flag raised.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_gain_match   <= 1'b0;
      r_pending_tog  <= 1'b0;
      r_pending_flag <= 1'b0;
      r_applied_tog  <= 1'b0;
      r_pending      <= UNITY_ALL;
      r_active       <= UNITY_ALL;
    end else begin
      r_gain_match <= gainToggle;
      if (w_commit) begin
        r_active      <= r_pending;
        r_applied_tog <= r_pending_tog;
      end
      if (w_capture) begin
        r_pending      <= gains;
        r_pending_tog  <= gainToggle;
        r_pending_flag <= 1'b1;
      end else if (w_commit) begin
        r_pending_flag <= 1'b0;
      end
    end
  end

  // S1: sample, frame and selected gain
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_valid <= 1'b0;
      r_s1_frame <= 1'b0;
      r_s1_data  <= '0;
      r_s1_gain  <= UNITY_ALL;
    end else begin
      r_s1_valid <= adcValid;
      r_s1_frame <= adcValid & adcFrame;
      r_s1_data  <= adcData;
      r_s1_gain  <= w_gain_sel;
    end
  end

  // Operands are extended to the full product width before multiplying so
  // the gain is treated as unsigned and the sample as signed.
  always_comb begin
    for (int n = 0; n < NADC; n++) begin
      w_op_a[n] = PW'($signed(r_s1_data[n*SW +: SW]));
      w_op_b[n] = PW'($signed({1'b0, r_s1_gain[n*GW +: GW]}));
      w_prod[n] = w_op_a[n] * w_op_b[n];
    end
  end

  // S2: multiply
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s2_valid <= 1'b0;
      r_s2_frame <= 1'b0;
      for (int n = 0; n < NADC; n++) begin
        r_s2_prod[n] <= '0;
      end
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_frame <= r_s1_frame;
      for (int n = 0; n < NADC; n++) begin
        r_s2_prod[n] <= w_prod[n];
      end
    end
  end

  // Round half up, then saturate to the sample range.
  always_comb begin
    w_res = '0;
    w_sat = '0;
    for (int n = 0; n < NADC; n++) begin
      w_rnd[n] = r_s2_prod[n] + RND_C;
      w_shr[n] = w_rnd[n] >>> (GW - 1);
      if (w_shr[n] > SAT_MAX) begin
        w_res[n*SW +: SW] = OUT_MAX;
        w_sat[n]          = 1'b1;
      end else if (w_shr[n] < SAT_MIN) begin
        w_res[n*SW +: SW] = OUT_MIN;
        w_sat[n]          = 1'b1;
      end else begin
        w_res[n*SW +: SW] = w_shr[n][SW-1:0];
      end
    end
  end

  // S3: output registers. A saturation event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_out_valid <= 1'b0;
      r_out_frame <= 1'b0;
      r_out_data  <= '0;
      r_sat_flags <= '0;
    end else begin
      r_out_valid <= r_s2_valid;
      r_out_frame <= r_s2_frame;
      if (r_s2_valid) begin
        r_out_data <= w_res;
      end
      r_sat_flags <= (satClearStrobe ? '0 : r_sat_flags) |
                     (r_s2_valid ? w_sat : '0);
    end
  end

  assign outValid      = r_out_valid;
  assign outFrame      = r_out_frame;
  assign outData       = r_out_data;
  assign appliedToggle = r_applied_tog;
  assign pendingFlag   = r_pending_flag;
  assign satFlags      = r_sat_flags;

endmodule

// File: tb/tb_gain_apply.sv
module tb_gain_apply;

  localparam int     N     = 4;
  localparam int     SW    = 16;
  localparam int     GW    = 25;
  localparam longint UNITY = 64'd1 << 24;
  localparam longint HALF  = 64'd1 << 23;
  localparam longint QUART = 64'd1 << 22;

  logic            clk = 1'b0;
  logic            resetN;
  logic            gainToggle;
  logic [N*GW-1:0] gains;
  logic            gainEnable;
  logic            satClearStrobe;
  logic            adcValid;
  logic            adcFrame;
  logic [N*SW-1:0] adcData;
  logic            outValid;
  logic            outFrame;
  logic [N*SW-1:0] outData;
  logic            appliedToggle;
  logic            pendingFlag;
  logic [N-1:0]    satFlags;

  int total = 0;
  int bad   = 0;

  gain_apply #(.NADC(N), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW)) dut (
    .clk(clk), .resetN(resetN), .gainToggle(gainToggle), .gains(gains),
    .gainEnable(gainEnable), .satClearStrobe(satClearStrobe),
    .adcValid(adcValid), .adcFrame(adcFrame), .adcData(adcData),
    .outValid(outValid), .outFrame(outFrame), .outData(outData),
    .appliedToggle(appliedToggle), .pendingFlag(pendingFlag),
    .satFlags(satFlags)
  );

  always #5 clk = ~clk;

  // Reference model: gain handshake state plus a 3-deep queue of expected outputs.
  typedef struct {
    bit         v;
    bit         f;
    logic [63:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t        q[$];
  bit          m_match, m_ptog, m_pflag, m_app;
  longint      m_pend[N];
  longint      m_act[N];
  logic [63:0] e_data;
  logic [3:0]  e_flags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void scale(input int s, input longint g, output int r, output bit sat);
    longint p;
    p = (longint'(s) * g + (64'sd1 <<< 23)) >>> 24;
    sat = 1'b0;
    if (p > 32767) begin
      p = 32767; sat = 1'b1;
    end else if (p < -32768) begin
      p = -32768; sat = 1'b1;
    end
    r = int'(p);
  endfunction

  task automatic model_reset();
    q.delete();
    m_match = 0; m_ptog = 0; m_pflag = 0; m_app = 0;
    for (int c = 0; c < N; c++) begin
      m_pend[c] = UNITY;
      m_act[c]  = UNITY;
    end
    e_data  = '0;
    e_flags = '0;
  endtask

  task automatic step();
    bit     cap, com, clr;
    ent_t   e;
    longint g;
    int     r;
    bit     s;
    cap = (gainToggle != m_match);
    com = adcValid && adcFrame && m_pflag;
    e.v = adcValid;
    e.f = adcValid && adcFrame;
    e.d = '0;
    e.s = '0;
    for (int c = 0; c < N; c++) begin
      g = !gainEnable ? UNITY : (com ? m_pend[c] : m_act[c]);
      scale(int'($signed(adcData[c*SW +: SW])), g, r, s);
      e.d[c*SW +: SW] = 16'(r);
      e.s[c] = s;
    end
    q.push_back(e);
    clr = satClearStrobe;
    if (com) begin
      m_act = m_pend;
      m_app = m_ptog;
    end
    if (cap) begin
      for (int c = 0; c < N; c++) m_pend[c] = longint'(gains[c*GW +: GW]);
      m_ptog  = gainToggle;
      m_pflag = 1;
    end else if (com) begin
      m_pflag = 0;
    end
    m_match = gainToggle;
    @(posedge clk);
    #1;
    if (clr) e_flags = '0;
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.v) begin
        e_data  = e.d;
        e_flags = e_flags | e.s;
      end
      chk("out_valid", outValid, e.v);
      chk("out_frame", outFrame, e.f);
    end else begin
      chk("out_valid_fill", outValid, 1'b0);
    end
    chk("out_data", outData, e_data);
    chk("sat_flags", satFlags, e_flags);
    chk("applied_toggle", appliedToggle, m_app);
    chk("pending_flag", pendingFlag, m_pflag);
  endtask

  task automatic set_gains(input longint g);
    for (int c = 0; c < N; c++) gains[c*GW +: GW] = g[GW-1:0];
  endtask

  task automatic set_all(input logic [15:0] v);
    adcData = {4{v}};
  endtask

  task automatic idle(input int n);
    adcValid = 0; adcFrame = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sample(input bit frame);
    adcValid = 1; adcFrame = frame;
    step();
    adcValid = 0; adcFrame = 0;
  endtask

  task automatic load_and_commit(input longint g);
    set_gains(g);
    gainToggle = ~gainToggle;
    idle(1);
    set_all(16'd0);
    sample(1'b1);
    idle(2);
  endtask

  initial begin
    resetN = 0; gainToggle = 0; gainEnable = 1; satClearStrobe = 0;
    adcValid = 0; adcFrame = 0; adcData = '0;
    set_gains(UNITY);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", outValid, 1'b0);
    chk("rst_out_data", outData, 64'd0);
    chk("rst_pending", pendingFlag, 1'b0);
    chk("rst_applied", appliedToggle, 1'b0);
    chk("rst_sat", satFlags, 4'd0);
    @(posedge clk);
    #1;
    resetN = 1;

    // unity pass-through
    adcData = {16'h8000, 16'hFFF9, 16'd5, 16'd1234};
    sample(1'b1);
    idle(2);
    chk("unity_ch0", outData[15:0], 16'd1234);
    chk("unity_ch3", outData[63:48], 16'h8000);
    chk("unity_valid", outValid, 1'b1);
    chk("unity_sat", satFlags, 4'd0);

    // rounding at gain 0.5
    set_gains(HALF);
    gainToggle = ~gainToggle;
    idle(1);
    chk("round_pending", pendingFlag, 1'b1);
    adcData = {16'hFFFF, 16'd1, 16'hFFFD, 16'd3};
    sample(1'b1);
    idle(2);
    chk("round_data", outData, 64'h0000_0001_FFFF_0002);

    // saturation and clear
    set_gains(64'h1FFFFFF);
    gainToggle = ~gainToggle;
    idle(1);
    adcData = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    sample(1'b1);
    idle(2);
    chk("sat_data", outData, 64'h8000_7FFF_8000_7FFF);
    chk("sat_flags_set", satFlags, 4'hF);
    satClearStrobe = 1;
    idle(1);
    satClearStrobe = 0;
    chk("sat_flags_clr", satFlags, 4'h0);

    // coherent commit mid-frame
    load_and_commit(UNITY);
    set_all(16'd1000);
    sample(1'b1);
    set_gains(HALF);
    gainToggle = ~gainToggle;
    sample(1'b0);
    chk("coh_pending", pendingFlag, 1'b1);
    sample(1'b0);
    sample(1'b0);
    sample(1'b1);
    chk("coh_applied", appliedToggle, gainToggle);
    idle(2);
    chk("coh_halved", outData[15:0], 16'd500);
    chk("coh_frame", outFrame, 1'b1);

    // last set wins
    load_and_commit(UNITY);
    set_all(16'd800);
    sample(1'b1);
    set_gains(HALF);
    gainToggle = ~gainToggle;
    sample(1'b0);
    sample(1'b0);
    set_gains(QUART);
    gainToggle = ~gainToggle;
    sample(1'b0);
    sample(1'b1);
    idle(2);
    chk("last_wins", outData[15:0], 16'd200);

    // bypass with a non-unity active set
    gainEnable = 0;
    adcData = {16'h8000, 16'h7FFF, 16'h1234, 16'hABCD};
    sample(1'b0);
    idle(2);
    chk("bypass", outData, 64'h8000_7FFF_1234_ABCD);
    gainEnable = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      adcValid       = ($urandom_range(0, 3) != 0);
      adcFrame       = ($urandom_range(0, 7) == 0);
      gainEnable     = ($urandom_range(0, 15) != 0);
      satClearStrobe = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < N; c++) adcData[c*SW +: SW] = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(0, 1) == 0)
            gains[c*GW +: GW] = 25'($urandom_range(32'h0C0_0000, 32'h140_0000));
          else
            gains[c*GW +: GW] = 25'($urandom);
        end
        gainToggle = ~gainToggle;
      end
      step();
    end
    satClearStrobe = 0;
    gainEnable = 1;

    // reset with a pending set and a full pipeline
    set_gains(QUART);
    gainToggle = ~gainToggle;
    set_all(16'd4000);
    adcValid = 1; adcFrame = 0;
    step();
    step();
    step();
    resetN = 0;
    #1;
    chk("mrst_valid", outValid, 1'b0);
    chk("mrst_data", outData, 64'd0);
    chk("mrst_pending", pendingFlag, 1'b0);
    chk("mrst_applied", appliedToggle, 1'b0);
    chk("mrst_sat", satFlags, 4'd0);
    model_reset();
    gainToggle = 0;
    adcValid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1;
    set_all(16'd4000);
    sample(1'b1);
    chk("post_rst_pending", pendingFlag, 1'b0);
    sample(1'b0);
    idle(1);
    chk("post_rst_unity", outData[15:0], 16'd4000);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
